// File: rtl/spi_master_mcs.sv
// spi_master_mcs: SPI master with NUM_CS chip selects, SPI modes 0-3 and CS-held back-to-back words.
// Optional LSB-first ordering is enabled with `define SPI_MASTER_LSB_FIRST_EN, which adds the lsb_first port.
module spi_master_mcs #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SPI_FREQ   = 5_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  keep_cs,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    output logic                  sclk,
    output logic [NUM_CS-1:0]     csn,
    output logic                  mosi,
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int HALF = CLK_FREQ / (2 * SPI_FREQ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int TW   = $clog2(2 * DATA_WIDTH);
    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [TW-1:0] TOG_LAST  = TW'(2 * DATA_WIDTH - 1);
    localparam logic [TW-1:0] TOG_FINAL = TW'(2 * DATA_WIDTH - 2);

    if (HALF < 1) begin : g_half_check
        $error("spi_master_mcs: CLK_FREQ/(2*SPI_FREQ) must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP, CSH} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tog_q, tog_d;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    mosi_q, mosi_d;
    logic                    sclk_q, sclk_d;
    logic [CSW-1:0]          cs_q, cs_d;
    logic                    cpol_q, cpol_d;
    logic                    cpha_q, cpha_d;
    logic                    lsb_q, lsb_d;
    logic                    rdy_q;
    logic                    lsb_in, idle, accept, half_end, edge_ev, last_tog;
    logic                    lead_ev, trail_ev, sample_ev, shift_ev, final_ev;
    logic                    ld_pha, ld_lsb, cs_act;
    logic [DATA_WIDTH-1:0]   rx_shift;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign idle      = state_q == IDLE;
    assign accept    = tx_valid && tx_ready;
    assign half_end  = cnt_q == HALF_M1;
    assign edge_ev   = (state_q == XFER) && half_end;
    assign last_tog  = tog_q == TOG_LAST;
    assign lead_ev   = edge_ev && !tog_q[0];
    assign trail_ev  = edge_ev && tog_q[0];
    assign sample_ev = cpha_q ? trail_ev : lead_ev;
    // In mode cpha=0 the final trailing edge would shift in a stale bit, so mosi is left holding the last one
    assign shift_ev  = cpha_q ? lead_ev : (trail_ev && !last_tog);
    assign final_ev  = sample_ev && (tog_q >= TOG_FINAL);
    // A word accepted in GAP reuses the frame's captured mode and bit order
    assign ld_pha    = idle ? cpha : cpha_q;
    assign ld_lsb    = idle ? lsb_in : lsb_q;
    assign rx_shift  = lsb_q ? {miso, rx_sh_q[DATA_WIDTH-1:1]} : {rx_sh_q[DATA_WIDTH-2:0], miso};

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    // State register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LEAD;
            LEAD:    if (half_end) state_d = XFER;
            XFER:    if (half_end && last_tog) state_d = TRAIL;
            TRAIL:   if (half_end) state_d = keep_cs ? GAP : CSH;
            GAP:     state_d = accept ? XFER : (keep_cs ? GAP : CSH);
            CSH:     if (half_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and chip-select outputs decoded from state
    always_comb begin
        cs_act   = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL) || (state_q == GAP);
        tx_ready = rdy_q && (idle || state_q == GAP);
        busy     = !idle;
        for (int i = 0; i < NUM_CS; i++) csn[i] = !(cs_act && cs_q == CSW'(i));
    end

    // Datapath next-state: half-period timer, edge counter, shifters and frame settings
    always_comb begin
        cnt_d      = (idle || state_q == GAP || half_end) ? '0 : cnt_q + 1'b1;
        tog_d      = edge_ev ? (last_tog ? '0 : tog_q + 1'b1) : tog_q;
        sclk_d     = idle ? cpol : (edge_ev ? ~sclk_q : sclk_q);
        cpol_d     = idle ? cpol : cpol_q;
        cs_d       = (idle && accept) ? cs_sel : cs_q;
        cpha_d     = (idle && accept) ? cpha : cpha_q;
        lsb_d      = (idle && accept) ? lsb_in : lsb_q;
        tx_sh_d    = accept ? (ld_pha ? tx_data : advance(tx_data, ld_lsb)) : (shift_ev ? advance(tx_sh_q, lsb_q) : tx_sh_q);
        mosi_d     = (accept && !ld_pha) ? first_bit(tx_data, ld_lsb) : (shift_ev ? first_bit(tx_sh_q, lsb_q) : mosi_q);
        rx_sh_d    = sample_ev ? rx_shift : rx_sh_q;
        rx_data_d  = final_ev ? rx_shift : rx_data_q;
        rx_valid_d = final_ev;
    end

    // Datapath registers; rdy_q keeps tx_ready low until the first edge after reset
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q      <= '0;
            tog_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tog_q      <= tog_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            rdy_q      <= 1'b1;
        end
    end

endmodule
